// File: rtl/reg_bank_dump_pkg.sv
// Purpose : shared mode codes, physical index constants and the address map for the banked register file.
// Latency : none (types, constants and a combinational helper only).
// Backpr. : not applicable.
// Contents: mode_e (ARM mode codes), PHYS_* physical indices, reg_loc_t, state_e, phys_map().
package reg_bank_dump_pkg;

  // ARM CPSR mode field encodings. MODE_NONE marks an index outside the banked file.
  typedef enum logic [4:0] {
    MODE_NONE = 5'b00000,
    MODE_USE  = 5'b10000,
    MODE_FIQ  = 5'b10001,
    MODE_IRQ  = 5'b10010,
    MODE_SVC  = 5'b10011,
    MODE_ABT  = 5'b10111,
    MODE_UND  = 5'b11011,
    MODE_SYS  = 5'b11111
  } mode_e;

  // Logical register numbers and the first physical slot of each banked group.
  localparam logic [4:0] PHYS_R8      = 5'd8;
  localparam logic [4:0] PHYS_R13     = 5'd13;
  localparam logic [4:0] PHYS_R15     = 5'd15;
  localparam logic [4:0] PHYS_R8_FIQ  = 5'd16;
  localparam logic [4:0] PHYS_R13_SVC = 5'd23;
  localparam logic [4:0] PHYS_R13_ABT = 5'd25;
  localparam logic [4:0] PHYS_R13_IRQ = 5'd27;
  localparam logic [4:0] PHYS_R13_UND = 5'd29;

  typedef struct packed {
    logic [4:0] mode;
    logic [3:0] addr;
  } reg_loc_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_SEND,
    ST_DONE
  } state_e;

  // Logical-to-physical address map: (mode, addr) -> physical index.
  // Registers not banked for the given mode resolve to the shared copy.
  function automatic logic [4:0] phys_map(input logic [4:0] mode, input logic [3:0] addr);
    logic [4:0] a5;
    logic       hi_pair;
    a5      = {1'b0, addr};
    hi_pair = (a5 >= PHYS_R13) && (a5 < PHYS_R15);
    phys_map = a5;
    case (mode)
      MODE_FIQ: if ((a5 >= PHYS_R8) && (a5 < PHYS_R15)) phys_map = PHYS_R8_FIQ + (a5 - PHYS_R8);
      MODE_SVC: if (hi_pair) phys_map = PHYS_R13_SVC + (a5 - PHYS_R13);
      MODE_ABT: if (hi_pair) phys_map = PHYS_R13_ABT + (a5 - PHYS_R13);
      MODE_IRQ: if (hi_pair) phys_map = PHYS_R13_IRQ + (a5 - PHYS_R13);
      MODE_UND: if (hi_pair) phys_map = PHYS_R13_UND + (a5 - PHYS_R13);
      default:  phys_map = a5;
    endcase
  endfunction

endpackage

// File: rtl/reg_bank_dump_unmap.sv
// Purpose : reverse address map, physical index -> canonical (mode, logical addr).
// Latency : combinational.
// Backpr. : not applicable.
// Ports   : phys_i[4:0] in; mode_o[4:0], addr_o[3:0] out (MODE_NONE / 4'hF past the last slot).
module reg_phys_unmap
  import reg_bank_dump_pkg::*;
(
  input  logic [4:0] phys_i,
  output logic [4:0] mode_o,
  output logic [3:0] addr_o
);

  always_comb begin
    mode_o = MODE_NONE;
    addr_o = 4'hF;
    if (phys_i <= PHYS_R15) begin
      // Shared registers are reported under user mode.
      mode_o = MODE_USE;
      addr_o = phys_i[3:0];
    end else if (phys_i < PHYS_R13_SVC) begin
      mode_o = MODE_FIQ;
      addr_o = 4'(phys_i - PHYS_R8_FIQ + PHYS_R8);
    end else if (phys_i < PHYS_R13_ABT) begin
      mode_o = MODE_SVC;
      addr_o = 4'(phys_i - PHYS_R13_SVC + PHYS_R13);
    end else if (phys_i < PHYS_R13_IRQ) begin
      mode_o = MODE_ABT;
      addr_o = 4'(phys_i - PHYS_R13_ABT + PHYS_R13);
    end else if (phys_i < PHYS_R13_UND) begin
      mode_o = MODE_IRQ;
      addr_o = 4'(phys_i - PHYS_R13_IRQ + PHYS_R13);
    end else if (phys_i < (PHYS_R13_UND + 5'd2)) begin
      mode_o = MODE_UND;
      addr_o = 4'(phys_i - PHYS_R13_UND + PHYS_R13);
    end
  end

endmodule

// File: rtl/reg_bank_dump.sv
// Purpose : walks every physical register, reads it over the spare port and streams (phys, mode, addr, data).
// Latency : first rf_re one cycle after start; 3 cycles per beat minimum; done one cycle after the last accept.
// Backpr. : beat held stable in SEND until out_ready; no new read is issued while stalled.
// Ports   : clk, rst (sync, active high), start -> busy, done; rf_re/rf_raddr -> rf_rdata;
//           out_valid/out_ready handshake carrying out_phys, out_mode, out_addr, out_data, out_last.
module reg_bank_dump
  import reg_bank_dump_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_PHYS = 31
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rf_re,
  output logic [4:0]        rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4:0]        out_phys,
  output logic [4:0]        out_mode,
  output logic [3:0]        out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  localparam logic [4:0] LAST_IDX = 5'(NUM_PHYS - 1);

  state_e            state_q;
  logic [4:0]        idx_q;
  logic [4:0]        idx_d;
  logic              busy_q, done_q, rf_re_q, out_valid_q, out_last_q;
  logic [4:0]        rf_raddr_q, out_phys_q;
  reg_loc_t          loc_q;
  reg_loc_t          loc_now;
  logic [DATA_W-1:0] out_data_q;

  assign idx_d = idx_q + 5'd1;

  reg_phys_unmap u_unmap (
    .phys_i (idx_q),
    .mode_o (loc_now.mode),
    .addr_o (loc_now.addr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rf_re_q     <= 1'b0;
      rf_raddr_q  <= '0;
      out_valid_q <= 1'b0;
      out_phys_q  <= '0;
      loc_q       <= '0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      // Read strobe and done are single-cycle unless re-armed below.
      rf_re_q    <= 1'b0;
      rf_raddr_q <= '0;
      done_q     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            idx_q      <= '0;
            busy_q     <= 1'b1;
            rf_re_q    <= 1'b1;
            rf_raddr_q <= '0;
            state_q    <= ST_REQ;
          end
        end
        ST_REQ: state_q <= ST_WAIT;
        ST_WAIT: begin
          // Read data lands now; register it together with its location tags.
          out_data_q  <= rf_rdata;
          out_phys_q  <= idx_q;
          loc_q       <= loc_now;
          out_last_q  <= (idx_q == LAST_IDX);
          out_valid_q <= 1'b1;
          state_q     <= ST_SEND;
        end
        ST_SEND: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (idx_q == LAST_IDX) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              idx_q      <= idx_d;
              rf_re_q    <= 1'b1;
              rf_raddr_q <= idx_d;
              state_q    <= ST_REQ;
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rf_re     = rf_re_q;
  assign rf_raddr  = rf_raddr_q;
  assign out_valid = out_valid_q;
  assign out_phys  = out_phys_q;
  assign out_mode  = loc_q.mode;
  assign out_addr  = loc_q.addr;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_reg_bank_dump.sv
module tb_reg_bank_dump;
  import reg_bank_dump_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, out_ready;
  logic        busy, done, rf_re, out_valid, out_last;
  logic [4:0]  rf_raddr, out_phys, out_mode;
  logic [3:0]  out_addr;
  logic [31:0] rf_rdata, out_data;
  logic [4:0]  um_phys, um_mode;
  logic [3:0]  um_addr;

  int checks = 0;
  int failures = 0;

  logic [4:0]  exp_mode [32];
  logic [3:0]  exp_addr [32];

  // Observations collected by run_dump.
  int          n_beats, n_done, done_cyc, first_re_cyc, n_re, re_bad, busy_bad, stall_bad;
  logic [4:0]  b_phys [64];
  logic [4:0]  b_mode [64];
  logic [3:0]  b_addr [64];
  logic [31:0] b_data [64];
  logic        b_last [64];
  int          b_cyc  [64];

  always #5 clk = ~clk;

  // Register file model: one-cycle read latency.
  always_ff @(posedge clk) begin
    if (rf_re) rf_rdata <= 32'hA000_0000 | {27'd0, rf_raddr};
  end

  reg_bank_dump #(.DATA_W(32), .NUM_PHYS(31)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rf_re(rf_re), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_phys(out_phys),
    .out_mode(out_mode), .out_addr(out_addr), .out_data(out_data), .out_last(out_last)
  );

  reg_phys_unmap u_um (.phys_i(um_phys), .mode_o(um_mode), .addr_o(um_addr));

  // Drives one dump and records what happens; cycle c counts edges after the one that samples start.
  task automatic run_dump(input int stall_beat, input int stall_len, input int p1, input int p2,
                          input bit start_on_done, input int abort_beat, output bit aborted);
    int         stall_cnt;
    bit         finished;
    logic [4:0] hold_phys;
    logic [31:0] hold_data;
    n_beats = 0; n_done = 0; done_cyc = -1; first_re_cyc = -1; n_re = 0;
    re_bad = 0; busy_bad = 0; stall_bad = 0; stall_cnt = 0; finished = 0; aborted = 0;
    hold_phys = '0; hold_data = '0;
    @(negedge clk);
    start = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 300 && !finished; c++) begin
      @(negedge clk);
      start = (c == p1) || (c == p2);
      out_ready = 1'b1;
      if (rf_re) begin
        if (first_re_cyc < 0) first_re_cyc = c;
        if (rf_raddr !== 5'(n_re)) re_bad++;
        n_re++;
      end else if (rf_raddr !== 5'd0) re_bad++;
      if (done ? (busy !== 1'b0) : (busy !== 1'b1)) busy_bad++;
      if (out_valid && out_phys == 5'(abort_beat)) begin
        rst = 1'b1;
        aborted = 1'b1;
        finished = 1'b1;
      end else if (out_valid) begin
        if (out_phys == 5'(stall_beat) && stall_cnt < stall_len) begin
          if (stall_cnt == 0) begin
            hold_phys = out_phys;
            hold_data = out_data;
          end else if (out_phys !== hold_phys || out_data !== hold_data) stall_bad++;
          if (rf_re) stall_bad++;
          out_ready = 1'b0;
          stall_cnt++;
        end else if (n_beats < 64) begin
          b_phys[n_beats] = out_phys;
          b_mode[n_beats] = out_mode;
          b_addr[n_beats] = out_addr;
          b_data[n_beats] = out_data;
          b_last[n_beats] = out_last;
          b_cyc[n_beats]  = c + 1;
          n_beats++;
        end
      end
      if (done) begin
        n_done++;
        done_cyc = c;
        start = start_on_done;
        finished = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; out_ready = 1'b0; um_phys = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, rf_re, out_valid, out_last} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b want 00000", {busy, done, rf_re, out_valid, out_last});
    end
    checks++;
    if ({rf_raddr, out_phys, out_mode, out_addr, out_data} !== 51'd0) begin
      failures++;
      $display("FAIL reset_data: raddr=%0d phys=%0d mode=%b addr=%0d data=%h want all 0",
               rf_raddr, out_phys, out_mode, out_addr, out_data);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_unmap();
    for (int i = 0; i < 32; i++) begin
      um_phys = 5'(i);
      #1;
      checks++;
      if (um_mode !== exp_mode[i] || um_addr !== exp_addr[i]) begin
        failures++;
        $display("FAIL unmap[%0d]: got mode=%b addr=%0d want mode=%b addr=%0d",
                 i, um_mode, um_addr, exp_mode[i], exp_addr[i]);
      end
      if (i < 31) begin
        checks++;
        if (phys_map(um_mode, um_addr) !== 5'(i)) begin
          failures++;
          $display("FAIL roundtrip[%0d]: got %0d want %0d", i, phys_map(um_mode, um_addr), i);
        end
      end
    end
  endtask

  task automatic test_full_dump();
    bit ab;
    int bad;
    run_dump(-1, 0, -1, -1, 1'b0, -1, ab);
    checks++;
    if (n_beats != 31) begin failures++; $display("FAIL dump_beats: got %0d want 31", n_beats); end
    checks++;
    if (b_phys[0] !== 5'd0 || b_mode[0] !== 5'b10000 || b_addr[0] !== 4'd0 || b_data[0] !== 32'hA000_0000) begin
      failures++;
      $display("FAIL beat0: got phys=%0d mode=%b addr=%0d data=%h want 0 10000 0 a0000000",
               b_phys[0], b_mode[0], b_addr[0], b_data[0]);
    end
    checks++;
    if (b_phys[30] !== 5'd30 || b_mode[30] !== 5'b11011 || b_addr[30] !== 4'd14 ||
        b_data[30] !== 32'hA000_001E || b_last[30] !== 1'b1) begin
      failures++;
      $display("FAIL beat30: got phys=%0d mode=%b addr=%0d data=%h last=%b want 30 11011 14 a000001e 1",
               b_phys[30], b_mode[30], b_addr[30], b_data[30], b_last[30]);
    end
    bad = 0;
    for (int k = 0; k < 31; k++) begin
      if (b_phys[k] !== 5'(k) || b_mode[k] !== exp_mode[k] || b_addr[k] !== exp_addr[k] ||
          b_data[k] !== (32'hA000_0000 | 32'(k)) || b_last[k] !== (k == 30) || b_cyc[k] != 3 + 3 * k)
        bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL dump_beat_fields: got %0d bad beats want 0", bad); end
    checks++;
    if (done_cyc != 93 || n_done != 1) begin
      failures++;
      $display("FAIL dump_done: got cycle=%0d count=%0d want cycle=93 count=1", done_cyc, n_done);
    end
    checks++;
    if (first_re_cyc != 0 || n_re != 31 || re_bad != 0) begin
      failures++;
      $display("FAIL dump_reads: got first=%0d n=%0d bad=%0d want 0 31 0", first_re_cyc, n_re, re_bad);
    end
    checks++;
    if (busy_bad != 0) begin failures++; $display("FAIL dump_busy: got %0d bad cycles want 0", busy_bad); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL done_pulse_width: got done=%b busy=%b want 0 0", done, busy);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_backpressure();
    bit ab;
    run_dump(7, 5, -1, -1, 1'b0, -1, ab);
    checks++;
    if (stall_bad != 0) begin failures++; $display("FAIL stall_hold: got %0d bad cycles want 0", stall_bad); end
    checks++;
    if (b_phys[7] !== 5'd7 || b_data[7] !== 32'hA000_0007 || b_cyc[7] != 29) begin
      failures++;
      $display("FAIL stall_beat7: got phys=%0d data=%h cyc=%0d want 7 a0000007 29", b_phys[7], b_data[7], b_cyc[7]);
    end
    checks++;
    if (b_phys[8] !== 5'd8 || b_cyc[8] != 32 || n_beats != 31 || done_cyc != 98) begin
      failures++;
      $display("FAIL stall_after: got phys8=%0d cyc8=%0d beats=%0d done=%0d want 8 32 31 98",
               b_phys[8], b_cyc[8], n_beats, done_cyc);
    end
    checks++;
    if (n_re != 31 || re_bad != 0) begin
      failures++;
      $display("FAIL stall_reads: got n=%0d bad=%0d want 31 0", n_re, re_bad);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_start_while_busy();
    bit ab;
    run_dump(-1, 0, 10, 40, 1'b0, -1, ab);
    checks++;
    if (n_beats != 31 || n_done != 1 || done_cyc != 93 || n_re != 31 || re_bad != 0) begin
      failures++;
      $display("FAIL busy_start: got beats=%0d dones=%0d done=%0d reads=%0d bad=%0d want 31 1 93 31 0",
               n_beats, n_done, done_cyc, n_re, re_bad);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_abort();
    bit ab;
    int late_done;
    run_dump(-1, 0, -1, -1, 1'b0, 12, ab);
    checks++;
    if (ab !== 1'b1) begin failures++; $display("FAIL abort_reach: got %b want 1", ab); end
    @(negedge clk);
    checks++;
    if ({busy, done, rf_re, out_valid, out_last, rf_raddr, out_phys, out_mode, out_addr, out_data} !== 56'd0) begin
      failures++;
      $display("FAIL abort_outputs: busy=%b done=%b re=%b vld=%b last=%b phys=%0d data=%h want all 0",
               busy, done, rf_re, out_valid, out_last, out_phys, out_data);
    end
    rst = 1'b0;
    late_done = 0;
    repeat (5) begin
      @(negedge clk);
      if (done) late_done++;
    end
    checks++;
    if (late_done != 0) begin failures++; $display("FAIL abort_no_done: got %0d pulses want 0", late_done); end
    run_dump(-1, 0, -1, -1, 1'b0, -1, ab);
    checks++;
    if (first_re_cyc != 0 || b_phys[0] !== 5'd0 || n_beats != 31 || done_cyc != 93) begin
      failures++;
      $display("FAIL abort_restart: got first=%0d phys0=%0d beats=%0d done=%0d want 0 0 31 93",
               first_re_cyc, b_phys[0], n_beats, done_cyc);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_start_in_done();
    bit ab;
    bit seen;
    run_dump(-1, 0, -1, -1, 1'b1, -1, ab);
    checks++;
    if (done_cyc != 93) begin failures++; $display("FAIL done_reach: got %0d want 93", done_cyc); end
    @(negedge clk);
    checks++;
    if (rf_re !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL done_start_ignored: got re=%b busy=%b want 0 0", rf_re, busy);
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (rf_re !== 1'b1 || rf_raddr !== 5'd0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL idle_start: got re=%b raddr=%0d busy=%b want 1 0 1", rf_re, rf_raddr, busy);
    end
    out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL second_dump_done: got timeout want done"); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      if (i < 16) begin exp_mode[i] = 5'b10000; exp_addr[i] = 4'(i); end
      else if (i < 23) begin exp_mode[i] = 5'b10001; exp_addr[i] = 4'(i - 8); end
      else if (i < 25) begin exp_mode[i] = 5'b10011; exp_addr[i] = 4'(13 + i - 23); end
      else if (i < 27) begin exp_mode[i] = 5'b10111; exp_addr[i] = 4'(13 + i - 25); end
      else if (i < 29) begin exp_mode[i] = 5'b10010; exp_addr[i] = 4'(13 + i - 27); end
      else if (i < 31) begin exp_mode[i] = 5'b11011; exp_addr[i] = 4'(13 + i - 29); end
      else begin exp_mode[i] = 5'b00000; exp_addr[i] = 4'hF; end
    end
    test_reset();
    test_unmap();
    test_full_dump();
    test_backpressure();
    test_start_while_busy();
    test_abort();
    test_start_in_done();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
